// File: rtl/mem_sync_init.sv
// mem_sync_init: parametrised single-port synchronous RAM with post-reset init sweep,
// configurable read latency, out-of-range detection and busy-time request rejection.
module mem_sync_init #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 4,
  parameter int                DEPTH    = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  output logic              rej
);
  typedef enum logic {INIT, RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d, d1_q, d1_d;
  logic              rd_valid_q, rd_valid_d, v1_q, v1_d;
  logic              err_q, err_d, rej_q, rej_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              init, oor, mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd, rdata;
  always_comb begin
    init       = state_q == INIT;
    oor        = 32'(address) >= DEPTH;
    rdata      = oor ? '0 : mem[address];
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (init) begin
      cnt_d   = (cnt_q == ADDR_W'(DEPTH - 1)) ? '0 : cnt_q + 1'b1;
      state_d = (cnt_q == ADDR_W'(DEPTH - 1)) ? RUN : INIT;
    end
    mem_we     = init || (wr && !oor);
    mem_wa     = init ? cnt_q : address;
    mem_wd     = init ? INIT_VAL : data_in;
    rej_d      = init && (wr || rd);
    err_d      = !init && (wr || rd) && oor;
    v1_d       = !init && rd;
    d1_d       = rdata;
    rd_valid_d = (RD_LAT == 2) ? v1_q : v1_d;
    data_out_d = rd_valid_d ? ((RD_LAT == 2) ? d1_q : rdata) : data_out_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      data_out_q <= '0;
      d1_q       <= '0;
      rd_valid_q <= 1'b0;
      v1_q       <= 1'b0;
      err_q      <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      d1_q       <= d1_d;
      rd_valid_q <= rd_valid_d;
      v1_q       <= v1_d;
      err_q      <= err_d;
      rej_q      <= rej_d;
    end
  // Array has no reset; the sweep runs only once reset is released.
  always_ff @(posedge clk)
    if (rst && mem_we) mem[mem_wa] <= mem_wd;
  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = init;
  assign err      = err_q;
  assign rej      = rej_q;
endmodule

// File: doc/mem_sync_init.md
Name: mem_sync_init

Overview:
Parametrised single-port synchronous RAM; successor to the fixed 8-bit x 16 memory. Configurable data width, depth and read latency. Adds a post-reset initialisation sweep with a busy flag, read-valid strobe, out-of-range address detection and request rejection. Used as the generic storage element for scratchpads and lookup tables.

Parameters:
DATA_W, 8, data word width in bits.
ADDR_W, 4, address width in bits.
DEPTH, 16, number of words; legal range 2..2**ADDR_W.
INIT_VAL, 0, value written to every word by the init sweep; DATA_W bits.
RD_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
data_in  in  DATA_W  write data.
address  in  ADDR_W  word address for read or write.
wr  in  1  write request, sampled on rising clk.
rd  in  1  read request, sampled on rising clk.
data_out  out  DATA_W  read data, registered.
rd_valid  out  1  one-cycle strobe; data_out holds a new read result.
busy  out  1  high while reset is asserted or the init sweep is running.
err  out  1  one-cycle strobe: accepted request addressed a word at or above DEPTH.
rej  out  1  one-cycle strobe: request (wr or rd) arrived while busy; request dropped.

Behaviour:
- Reset (rst=0, asynchronous): data_out=0, rd_valid=0, err=0, rej=0, busy=1, sweep counter=0, FSM enters INIT. Array contents are not cleared asynchronously.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle after rst deasserts, write INIT_VAL to array[counter] and increment the counter.
  - After writing word DEPTH-1, enter RUN and drop busy at the same edge.
  - busy is high for exactly DEPTH cycles after the first rising edge with rst=1.
- In INIT, any wr or rd causes rej=1 the next cycle. The array and data_out are unchanged.
- Reset asserted mid-INIT or mid-RUN: the sweep restarts from word 0 after release. In-flight reads are discarded; rd_valid stays 0.
- RUN write (wr=1, address<DEPTH): array[address] <= data_in at that edge.
- RUN read, address<DEPTH:
  - RD_LAT=1: data_out <= array[address] and rd_valid=1 on the next cycle.
  - RD_LAT=2: one additional register stage; data_out and rd_valid appear one cycle later.
  - Back-to-back reads are fully pipelined, one per cycle.
- wr and rd both high, same address: read-before-write. data_out returns the old word; the new value is stored.
- Out-of-range (address >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Write is ignored.
  - Read completes normally (rd_valid pulses, same latency) with data_out=0.
  - err pulses 1 in the cycle following the request, for both wr and rd.
- No read: data_out holds its last value; rd_valid=0.
- err and rej are never both 1 in the same cycle.
- Width rules: no truncation. DATA_W-wide array; address compared as unsigned ADDR_W-bit against DEPTH.

Test Plan:
1. Default params. Hold rst=0 3 cycles, release. Drive rd=1 addr 0 during the first cycle -> rej=1 next cycle; busy high exactly 16 cycles, then 0. Afterwards, read of every address returns 0.
2. Default params after init. Write i*5 to addr i for i=0..15, then read 0..15 back-to-back -> rd_valid high 16 consecutive cycles; data_out=0,5,...,75 in order, 1 cycle after each rd.
3. RD_LAT=2, DATA_W=16. Write 16'hBEEF to addr 3, then read addr 3 -> data_out=16'hBEEF, rd_valid=1 exactly 2 cycles after rd.
4. Addr 7 holds 35. Assert wr=1 and rd=1 on addr 7 with data_in=99 -> data_out=35 next cycle; a subsequent read of addr 7 returns 99.
5. DEPTH=12, ADDR_W=4. Write 8'hAA to addr 13 -> err=1 next cycle. Read addr 13 -> err=1, rd_valid=1, data_out=0. Array words 0..11 are unchanged.
6. Pull rst low mid-sweep (cycle 5 of INIT), release after 2 cycles -> busy stays high a further full 16 cycles; no rd_valid during that time.
